// File: rtl/delay_var_line.sv
// delay_var_line: stallable delay line whose depth is set at run time.
// A valid bit travels with every word, and an occupancy count tracks the
// valid words inside the active window so controllers can drain the line
// before they reconfigure it.
// Optional feature macro: DELAY_VAR_LINE_OUTREG_EN adds an output register
// stage after the tap. That register counts as one extra stage of latency
// and of occupancy.
module delay_var_line #(
  parameter int SIG_DATA_WIDTH = 16,
  parameter int MAX_DELAY      = 16,
`ifdef DELAY_VAR_LINE_OUTREG_EN
  localparam int DSEL_W        = $clog2(MAX_DELAY + 2)
`else
  localparam int DSEL_W        = $clog2(MAX_DELAY + 1)
`endif
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      en,
  input  logic                      cfg_load,
  input  logic [DSEL_W-1:0]         delay_sel,
  input  logic                      Valid_In,
  input  logic [SIG_DATA_WIDTH-1:0] Data_In,
  output logic                      Valid_Out,
  output logic [SIG_DATA_WIDTH-1:0] Data_Out,
  output logic [DSEL_W-1:0]         occupancy,
  output logic                      busy
);

  // The tap is stored as act_dly-1, so it indexes the arrays directly.
  localparam int IDX_W = $clog2(MAX_DELAY);

  logic [SIG_DATA_WIDTH-1:0] r_d [MAX_DELAY];
  logic [MAX_DELAY-1:0]      r_v;
  logic [IDX_W-1:0]          r_tap;
  logic [DSEL_W-1:0]         r_occ;

  logic                      w_tap_v;
  logic [SIG_DATA_WIDTH-1:0] w_tap_d;
  logic                      w_exit;

  // Map a requested delay onto a tap index. A request of 0 selects 1 stage,
  // and any request above MAX_DELAY selects MAX_DELAY stages.
  function automatic logic [IDX_W-1:0] clamp_tap(input logic [DSEL_W-1:0] sel);
    logic [DSEL_W-1:0] dec;
    dec = sel - DSEL_W'(1);
    if (sel == '0) return '0;
    if (sel > DSEL_W'(MAX_DELAY)) return IDX_W'(MAX_DELAY - 1);
    return IDX_W'(dec);
  endfunction

  assign w_tap_v = r_v[r_tap];
  assign w_tap_d = r_d[r_tap];

  // Data shift array. A reconfiguration keeps the stored words, because the
  // cleared valid bits already mark them as stale.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < MAX_DELAY; i++) r_d[i] <= '0;
    end else if (en && !cfg_load) begin
      r_d[0] <= Data_In;
      for (int i = 1; i < MAX_DELAY; i++) r_d[i] <= r_d[i-1];
    end
  end

  // Valid shift array, active tap and occupancy. cfg_load flushes the line
  // and takes priority over en.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_v   <= '0;
      r_tap <= IDX_W'(MAX_DELAY - 1);
      r_occ <= '0;
    end else if (cfg_load) begin
      r_v   <= '0;
      r_tap <= clamp_tap(delay_sel);
      r_occ <= '0;
    end else if (en) begin
      r_v   <= {r_v[MAX_DELAY-2:0], Valid_In};
      r_occ <= r_occ + DSEL_W'(Valid_In) - DSEL_W'(w_exit);
    end
  end

`ifdef DELAY_VAR_LINE_OUTREG_EN
  logic                      r_vout;
  logic [SIG_DATA_WIDTH-1:0] r_dout;

  // Output register stage. A word leaves the occupancy window when it leaves
  // this register, not when it leaves the tap.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_vout <= 1'b0;
      r_dout <= '0;
    end else if (cfg_load) begin
      r_vout <= 1'b0;
    end else if (en) begin
      r_vout <= w_tap_v;
      r_dout <= w_tap_d;
    end
  end

  assign w_exit    = r_vout;
  assign Valid_Out = r_vout;
  assign Data_Out  = r_dout;
`else
  assign w_exit    = w_tap_v;
  assign Valid_Out = w_tap_v;
  assign Data_Out  = w_tap_d;
`endif

  assign occupancy = r_occ;
  assign busy      = |r_occ;

endmodule

// File: tb/tb_delay_var_line.sv
// Bench for delay_var_line at SIG_DATA_WIDTH=16, MAX_DELAY=16.
// It builds with or without DELAY_VAR_LINE_OUTREG_EN.
module tb_delay_var_line;

  localparam int W    = 16;
  localparam int MAXD = 16;
`ifdef DELAY_VAR_LINE_OUTREG_EN
  localparam int OR     = 1;
  localparam int DSEL_W = $clog2(MAXD + 2);
`else
  localparam int OR     = 0;
  localparam int DSEL_W = $clog2(MAXD + 1);
`endif

  logic              clk;
  logic              reset;
  logic              en;
  logic              cfg_load;
  logic [DSEL_W-1:0] delay_sel;
  logic              Valid_In;
  logic [W-1:0]      Data_In;
  logic              Valid_Out;
  logic [W-1:0]      Data_Out;
  logic [DSEL_W-1:0] occupancy;
  logic              busy;

  delay_var_line #(.SIG_DATA_WIDTH(W), .MAX_DELAY(MAXD)) dut (
    .clk(clk), .reset(reset), .en(en), .cfg_load(cfg_load),
    .delay_sel(delay_sel), .Valid_In(Valid_In), .Data_In(Data_In),
    .Valid_Out(Valid_Out), .Data_Out(Data_Out),
    .occupancy(occupancy), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [W-1:0] data;
    int           due;
  } exp_t;

  exp_t sb[$];
  int   ecnt = 0;
  int   lat  = MAXD + OR;
  int   n_tests = 0;
  int   n_fail  = 0;

  function automatic int clamp_lat(input int ds);
    if (ds == 0) return 1;
    if (ds > MAXD) return MAXD;
    return ds;
  endfunction

  // Scoreboard: each accepted word is pushed with the shift count at which
  // it must sit at the output, and it is popped on the shift that moves it
  // out. The expected occupancy is the number of words in the queue.
  initial begin : monitor
    logic              s_rst, s_en, s_cl, s_vi;
    logic [DSEL_W-1:0] s_ds;
    logic [W-1:0]      s_di;
    logic              exp_v;
    forever begin
      @(posedge clk);
      s_rst = reset; s_en = en; s_cl = cfg_load;
      s_ds = delay_sel; s_vi = Valid_In; s_di = Data_In;
      if (!s_rst) begin
        sb.delete();
        lat = MAXD + OR;
      end else if (s_cl) begin
        sb.delete();
        lat = clamp_lat(int'(s_ds)) + OR;
      end else if (s_en) begin
        if (sb.size() > 0 && sb[0].due == ecnt) void'(sb.pop_front());
        ecnt++;
        if (s_vi) sb.push_back('{data: s_di, due: ecnt + lat - 1});
      end
      #1;
      if (reset) begin
        exp_v = (sb.size() > 0) && (sb[0].due == ecnt);
        n_tests++;
        if (Valid_Out !== exp_v) begin
          n_fail++;
          $display("FAIL sb_valid: got %0b want %0b at %0t", Valid_Out, exp_v, $time);
        end
        if (exp_v) begin
          n_tests++;
          if (Data_Out !== sb[0].data) begin
            n_fail++;
            $display("FAIL sb_data: got %0h want %0h at %0t", Data_Out, sb[0].data, $time);
          end
        end
        n_tests++;
        if (int'(occupancy) != sb.size() || busy !== (sb.size() != 0)) begin
          n_fail++;
          $display("FAIL sb_occ: got occ=%0d busy=%0b want occ=%0d at %0t",
                   occupancy, busy, sb.size(), $time);
        end
      end
    end
  end

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "bench timeout");
  end

  task automatic drive(input logic e, input logic cl, input logic [DSEL_W-1:0] ds,
                       input logic vi, input logic [W-1:0] di);
    en = e; cfg_load = cl; delay_sel = ds; Valid_In = vi; Data_In = di;
    @(posedge clk); #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((busy !== 1'b0 || Valid_Out !== 1'b0) && n < 64) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      n++;
    end
    n_tests++;
    if (n >= 64) begin
      n_fail++;
      $display("FAIL drain: got busy=%0b after %0d cycles want 0", busy, n);
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive(1'b1, 1'b0, '0, 1'b1, 16'h1234);
    repeat (3) begin
      drive(1'b1, 1'b0, '0, 1'b1, 16'h1234);
      n_tests++;
      if (Valid_Out !== 1'b0 || Data_Out !== '0 || occupancy !== '0 || busy !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_outputs: got v=%0b d=%0h occ=%0d busy=%0b want all 0",
                 Valid_Out, Data_Out, occupancy, busy);
      end
    end
    en = 1'b1; Valid_In = 1'b0; Data_In = '0;
    reset = 1'b1;
  endtask

  task automatic test_default_delay();
    int cnt;
    drive(1'b1, 1'b0, '0, 1'b1, 16'h00A5);
    cnt = 1;
    while (Valid_Out !== 1'b1 && cnt < 64) begin
      n_tests++;
      if (occupancy !== DSEL_W'(1)) begin
        n_fail++;
        $display("FAIL default_occ: got %0d want 1", occupancy);
      end
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      cnt++;
    end
    n_tests++;
    if (cnt != MAXD + OR) begin
      n_fail++;
      $display("FAIL default_latency: got %0d want %0d", cnt, MAXD + OR);
    end
    n_tests++;
    if (Data_Out !== 16'h00A5) begin
      n_fail++;
      $display("FAIL default_data: got %0h want 00a5", Data_Out);
    end
    drain();
  endtask

  // Each row gives a requested delay, the expected latency without the output
  // register, and the en level during the cfg_load cycle. The 5-bit port
  // cannot carry 40, so the largest code (31) and 17 stand in for an
  // over-range request.
  task automatic test_delay_clamp();
    int ds_t [5] = '{5, 0, 31, 17, 2};
    int lt_t [5] = '{5, 1, 16, 16, 2};
    logic en_t [5] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    int cnt;
    logic [W-1:0] dat;
    for (int k = 0; k < 5; k++) begin
      drive(en_t[k], 1'b1, DSEL_W'(ds_t[k]), 1'b0, '0);
      dat = W'(16'hB000 + k);
      drive(1'b1, 1'b0, '0, 1'b1, dat);
      cnt = 1;
      while (Valid_Out !== 1'b1 && cnt < 64) begin
        drive(1'b1, 1'b0, '0, 1'b0, '0);
        cnt++;
      end
      n_tests++;
      if (cnt != lt_t[k] + OR || Data_Out !== dat) begin
        n_fail++;
        $display("FAIL delay_sel_%0d: got lat=%0d data=%0h want lat=%0d data=%0h",
                 ds_t[k], cnt, Data_Out, lt_t[k] + OR, dat);
      end
      drain();
    end
  endtask

  task automatic test_back_to_back_cfg();
    int cnt;
    drive(1'b1, 1'b1, DSEL_W'(3), 1'b0, '0);
    drive(1'b1, 1'b1, DSEL_W'(6), 1'b0, '0);
    drive(1'b1, 1'b0, '0, 1'b1, 16'hC6C6);
    cnt = 1;
    while (Valid_Out !== 1'b1 && cnt < 64) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      cnt++;
    end
    n_tests++;
    if (cnt != 6 + OR) begin
      n_fail++;
      $display("FAIL back_to_back_cfg: got lat=%0d want %0d", cnt, 6 + OR);
    end
    drain();
  endtask

  task automatic test_stall();
    int nxt, n;
    logic         hv;
    logic [W-1:0] hd;
    drive(1'b1, 1'b1, DSEL_W'(4), 1'b0, '0);
    nxt = 1;
    for (int i = 1; i <= 20; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1, W'(i));
      if (Valid_Out === 1'b1) begin
        n_tests++;
        if (Data_Out !== W'(nxt)) begin
          n_fail++;
          $display("FAIL stall_order: got %0d want %0d", Data_Out, nxt);
        end
        nxt++;
      end
      if (i == 10) begin
        hv = Valid_Out; hd = Data_Out;
        repeat (3) begin
          drive(1'b0, 1'b0, '0, 1'b1, W'(11));
          n_tests++;
          if (Valid_Out !== hv || Data_Out !== hd || occupancy !== DSEL_W'(4 + OR)) begin
            n_fail++;
            $display("FAIL stall_hold: got v=%0b d=%0h occ=%0d want v=%0b d=%0h occ=%0d",
                     Valid_Out, Data_Out, occupancy, hv, hd, 4 + OR);
          end
        end
      end
    end
    n = 0;
    while (nxt <= 20 && n < 32) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      n++;
      if (Valid_Out === 1'b1) begin
        n_tests++;
        if (Data_Out !== W'(nxt)) begin
          n_fail++;
          $display("FAIL stall_order: got %0d want %0d", Data_Out, nxt);
        end
        nxt++;
      end
    end
    n_tests++;
    if (nxt != 21) begin
      n_fail++;
      $display("FAIL stall_count: got %0d words want 20", nxt - 1);
    end
    drain();
  endtask

  task automatic test_flush();
    drive(1'b1, 1'b1, DSEL_W'(4), 1'b0, '0);
    for (int i = 0; i < 6; i++) drive(1'b1, 1'b0, '0, 1'b1, W'(16'h30 + i));
    n_tests++;
    if (occupancy !== DSEL_W'(4 + OR)) begin
      n_fail++;
      $display("FAIL flush_pre_occ: got %0d want %0d", occupancy, 4 + OR);
    end
    drive(1'b1, 1'b1, DSEL_W'(8), 1'b1, 16'h0077);
    n_tests++;
    if (occupancy !== '0 || busy !== 1'b0 || Valid_Out !== 1'b0) begin
      n_fail++;
      $display("FAIL flush_clear: got occ=%0d busy=%0b v=%0b want 0 0 0",
               occupancy, busy, Valid_Out);
    end
    repeat (8) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      n_tests++;
      if (Valid_Out !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_quiet: got v=%0b d=%0h want v=0", Valid_Out, Data_Out);
      end
    end
  endtask

  task automatic test_peak_occupancy();
    int peak;
    drive(1'b1, 1'b1, DSEL_W'(5), 1'b0, '0);
    peak = 0;
    for (int i = 0; i < 12; i++) begin
      drive(1'b1, 1'b0, '0, 1'b1, W'(16'h50 + i));
      if (int'(occupancy) > peak) peak = int'(occupancy);
    end
    n_tests++;
    if (peak != 5 + OR) begin
      n_fail++;
      $display("FAIL peak_occ: got %0d want %0d", peak, 5 + OR);
    end
    drain();
  endtask

  task automatic test_async_reset();
    int cnt;
    for (int i = 0; i < 8; i++) drive(1'b1, 1'b0, '0, 1'b1, W'(16'h90 + i));
    n_tests++;
    if (Valid_Out !== 1'b1 || occupancy !== DSEL_W'(5 + OR)) begin
      n_fail++;
      $display("FAIL areset_pre: got v=%0b occ=%0d want v=1 occ=%0d",
               Valid_Out, occupancy, 5 + OR);
    end
    Valid_In = 1'b0;
    #2;
    reset = 1'b0;
    #1;
    n_tests++;
    if (Valid_Out !== 1'b0 || Data_Out !== '0 || occupancy !== '0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL areset_immediate: got v=%0b d=%0h occ=%0d busy=%0b want all 0",
               Valid_Out, Data_Out, occupancy, busy);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    drive(1'b1, 1'b0, '0, 1'b1, 16'hD00D);
    cnt = 1;
    while (Valid_Out !== 1'b1 && cnt < 64) begin
      drive(1'b1, 1'b0, '0, 1'b0, '0);
      cnt++;
    end
    n_tests++;
    if (cnt != MAXD + OR || Data_Out !== 16'hD00D) begin
      n_fail++;
      $display("FAIL areset_latency: got lat=%0d data=%0h want lat=%0d data=d00d",
               cnt, Data_Out, MAXD + OR);
    end
    drain();
  endtask

  initial begin : main
    reset = 1'b0; en = 1'b0; cfg_load = 1'b0; delay_sel = '0;
    Valid_In = 1'b0; Data_In = '0;
    test_reset();
    test_default_delay();
    test_delay_clamp();
    test_back_to_back_cfg();
    test_stall();
    test_flush();
    test_peak_occupancy();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
